// File: rtl/spike_arbiter.sv
// Round-robin spike arbiter: latches the ternary spike_out of every neuron, picks one
// firing neuron with a rotating priority search and broadcasts its {value, id}.
module spike_arbiter #(
    parameter int  TEN_DATA_WIDTH  = 2,
    parameter int  NUM_NEURON      = 64,
    parameter int  NEURON_ID_WIDTH = 10,
    localparam int SPIKE_OUT_WIDTH = TEN_DATA_WIDTH + NEURON_ID_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset_l,
    input  logic                                 en_network,
    input  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0] spike_bus,
    output logic [SPIKE_OUT_WIDTH-1:0]           spike_out,
    output logic                                 networkDone,
    output logic                                 noSpike,
    output logic [15:0]                          spikeCount
);

    localparam int PTR_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, BCAST} state_e;

    state_e                      state_q, state_d;
    logic [TEN_DATA_WIDTH-1:0]   pending_q [NUM_NEURON];
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [SPIKE_OUT_WIDTH-1:0]  spike_out_q, spike_out_d;
    logic                        done_q, done_d;
    logic                        nospike_q, nospike_d;
    logic [15:0]                 count_q, count_d;

    logic                        found;
    logic [PTR_W-1:0]            win;
    logic [TEN_DATA_WIDTH-1:0]   win_code;
    logic [PTR_W:0]              idx;
    logic                        capture;

    // Codes 01 (-1) and 10 (+1) fire; 00 and the reserved 11 do not.
    function automatic logic is_firing(input logic [TEN_DATA_WIDTH-1:0] code);
        return (code == TEN_DATA_WIDTH'(1)) || (code == TEN_DATA_WIDTH'(2));
    endfunction

    assign capture = (state_q == IDLE) && en_network;

    // Rotated priority search: first firing index starting at ptr, wrapping at NUM_NEURON.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        found    = 1'b0;
        win      = '0;
        win_code = '0;
        idx      = '0;
        for (int i = 0; i < NUM_NEURON; i++) begin
            idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_NEURON)) begin
                idx = idx - (PTR_W+1)'(NUM_NEURON);
            end
            if (!found && is_firing(pending_q[idx[PTR_W-1:0]])) begin
                found    = 1'b1;
                win      = idx[PTR_W-1:0];
                win_code = pending_q[idx[PTR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_network) state_d = CAPTURE;
            CAPTURE: state_d = BCAST;
            BCAST:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        spike_out_d = spike_out_q;
        done_d      = 1'b0;
        nospike_d   = 1'b0;
        count_d     = count_q;
        if (state_q == CAPTURE) begin
            done_d = 1'b1;
            if (found) begin
                spike_out_d = {win_code, NEURON_ID_WIDTH'(win)};
                ptr_d       = (win == PTR_W'(NUM_NEURON - 1)) ? '0 : win + PTR_W'(1);
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end else begin
                spike_out_d = '0;
                nospike_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            // NOTE: the pending array is reset because a reset is defined to clear it, not just the control state.
            for (int i = 0; i < NUM_NEURON; i++) begin
                pending_q[i] <= '0;
            end
            ptr_q       <= '0;
            spike_out_q <= '0;
            done_q      <= 1'b0;
            nospike_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            if (capture) begin
                for (int i = 0; i < NUM_NEURON; i++) begin
                    pending_q[i] <= spike_bus[i*TEN_DATA_WIDTH +: TEN_DATA_WIDTH];
                end
            end
            ptr_q       <= ptr_d;
            spike_out_q <= spike_out_d;
            done_q      <= done_d;
            nospike_q   <= nospike_d;
            count_q     <= count_d;
        end
    end

    assign spike_out   = spike_out_q;
    assign networkDone = done_q;
    assign noSpike     = nospike_q;
    assign spikeCount  = count_q;

endmodule

// File: tb/tb_spike_arbiter.sv
// Scoreboard bench for spike_arbiter: directed rounds push hand-computed broadcasts,
// a negedge monitor pops and compares whenever networkDone is high.
module tb_spike_arbiter;

    localparam int TDW = 2;
    localparam int NN  = 64;
    localparam int IDW = 10;
    localparam int SOW = TDW + IDW;
    localparam int BW  = NN * TDW;

    logic           clk        = 1'b0;
    logic           reset_l    = 1'b1;
    logic           en_network = 1'b0;
    logic [BW-1:0]  spike_bus  = '0;
    logic [SOW-1:0] spike_out;
    logic           networkDone;
    logic           noSpike;
    logic [15:0]    spikeCount;

    spike_arbiter #(
        .TEN_DATA_WIDTH (TDW),
        .NUM_NEURON     (NN),
        .NEURON_ID_WIDTH(IDW)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .en_network (en_network),
        .spike_bus  (spike_bus),
        .spike_out  (spike_out),
        .networkDone(networkDone),
        .noSpike    (noSpike),
        .spikeCount (spikeCount)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        logic [SOW-1:0] out;
        logic           ns;
        logic [15:0]    cnt;
        int             edge_n;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks  = 0;
    int          n_pass    = 0;
    logic [15:0] model_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [BW-1:0] one_hot(input int idx, input logic [1:0] code);
        logic [BW-1:0] b;
        b = '0;
        b[idx*TDW +: TDW] = code;
        return b;
    endfunction

    function automatic logic [BW-1:0] null_bus();
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < NN; i++) b[i*TDW +: TDW] = (i % 3 == 0) ? 2'b11 : 2'b00;
        return b;
    endfunction

    // Monitor: every networkDone cycle must match the oldest expected broadcast.
    always @(negedge clk) begin
        if (networkDone === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: networkDone=1 at edge %0d, required 0", edge_cnt);
            end else begin
                mon_e = sb.pop_front();
                check("spike_out",  32'(spike_out),  32'(mon_e.out));
                check("noSpike",    32'(noSpike),    32'(mon_e.ns));
                check("spikeCount", 32'(spikeCount), 32'(mon_e.cnt));
                check("done_edge",  32'(edge_cnt),   32'(mon_e.edge_n));
            end
        end
    end

    // Called just after a negedge; occupies exactly three cycles (minimum round period).
    task automatic round(input logic [BW-1:0] bus, input logic [SOW-1:0] exp_out, input logic exp_ns);
        exp_t e;
        spike_bus  = bus;
        en_network = 1'b1;
        if (!exp_ns && model_cnt != 16'hFFFF) model_cnt++;
        e.out    = exp_out;
        e.ns     = exp_ns;
        e.cnt    = model_cnt;
        e.edge_n = edge_cnt + 2;
        sb.push_back(e);
        @(negedge clk);
        en_network = 1'b0;
        spike_bus  = {NN{2'b10}};
        @(negedge clk);
        @(negedge clk);
    endtask

    logic [BW-1:0] rr_bus, wrap_bus, lo_bus;
    exp_t          held;

    initial begin
        rr_bus   = one_hot(5, 2'b01)  | one_hot(58, 2'b10);
        wrap_bus = one_hot(63, 2'b10) | one_hot(0, 2'b01);
        lo_bus   = one_hot(0, 2'b01)  | one_hot(1, 2'b10);

        // Asynchronous reset mid-cycle with en_network held high
        #2;
        reset_l    = 1'b0;
        en_network = 1'b1;
        spike_bus  = one_hot(13, 2'b10);
        #1;
        check("rst_spike_out",   32'(spike_out),   32'h0);
        check("rst_networkDone", 32'(networkDone), 32'h0);
        check("rst_noSpike",     32'(noSpike),     32'h0);
        check("rst_spikeCount",  32'(spikeCount),  32'h0);
        repeat (3) @(negedge clk);
        check("rst_hold_done",  32'(networkDone), 32'h0);
        check("rst_hold_count", 32'(spikeCount),  32'h0);

        // Single spike: neuron 13 = +1, ptr 0 -> ptr 14
        reset_l = 1'b1;
        round(one_hot(13, 2'b10), 12'h80D, 1'b0);
        check("hold_spike_out", 32'(spike_out),   32'h80D);
        check("hold_done_low",  32'(networkDone), 32'h0);

        // Fresh reset so round-robin starts at ptr 0
        reset_l   = 1'b0;
        model_cnt = '0;
        #1;
        check("rst2_spikeCount", 32'(spikeCount), 32'h0);
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);

        round(rr_bus, 12'h405, 1'b0);
        round(rr_bus, 12'h83A, 1'b0);
        round(rr_bus, 12'h405, 1'b0);
        round(rr_bus, 12'h83A, 1'b0);

        // Wrap boundary: 62 wins -> ptr 63; then 63 wins -> ptr 0; then 0 wins
        round(one_hot(62, 2'b01), 12'h43E, 1'b0);
        round(wrap_bus, 12'h83F, 1'b0);
        round(wrap_bus, 12'h400, 1'b0);

        // No firing neuron (codes 00 / 11): ptr stays 1, count unchanged
        round(null_bus(), 12'h000, 1'b1);
        round(lo_bus, 12'h801, 1'b0);
        check("hold_spike_out2", 32'(spike_out), 32'h801);
        check("hold_noSpike",    32'(noSpike),   32'h0);

        // en_network held high for 5 cycles: rounds 3 cycles apart, en ignored outside IDLE
        spike_bus  = one_hot(7, 2'b01);
        en_network = 1'b1;
        model_cnt++;
        held.out = 12'h407; held.ns = 1'b0; held.cnt = model_cnt; held.edge_n = edge_cnt + 2;
        sb.push_back(held);
        model_cnt++;
        held.cnt = model_cnt; held.edge_n = edge_cnt + 5;
        sb.push_back(held);
        repeat (5) @(negedge clk);
        en_network = 1'b0;
        repeat (3) @(negedge clk);

        // Reset while in CAPTURE: no networkDone, ptr back to 0
        spike_bus  = one_hot(20, 2'b10);
        en_network = 1'b1;
        @(negedge clk);
        en_network = 1'b0;
        reset_l    = 1'b0;
        #1;
        check("midrst_spike_out",  32'(spike_out),   32'h0);
        check("midrst_done",       32'(networkDone), 32'h0);
        check("midrst_spikeCount", 32'(spikeCount),  32'h0);
        repeat (2) @(negedge clk);
        reset_l   = 1'b1;
        model_cnt = '0;
        @(negedge clk);
        round(rr_bus, 12'h405, 1'b0);

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
